// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands and control for EX, inserts a
// bubble on load-use hazards against the EX slot, and bypasses same-cycle WB writes.
module id_ex_stage #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned ALUOP_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               id_valid,
    input  logic [XLEN-1:0]    id_pc,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [XLEN-1:0]    id_rs1_data,
    input  logic [XLEN-1:0]    id_rs2_data,
    input  logic [XLEN-1:0]    id_imm,
    input  logic [6:0]         id_ctrl,
    input  logic [ALUOP_W-1:0] id_aluop,
    input  logic               wb_reg_write,
    input  logic [4:0]         wb_rd,
    input  logic [XLEN-1:0]    wb_data,
    output logic               stall_if_id,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [XLEN-1:0]    ex_imm,
    output logic [XLEN-1:0]    ex_rs1_data,
    output logic [XLEN-1:0]    ex_rs2_data,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [6:0]         ex_ctrl,
    output logic [ALUOP_W-1:0] ex_aluop
);

    localparam int unsigned REG_W = 5;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
        logic alu_src;
        logic branch;
        logic jump;
    } ctrl_t;

    ctrl_t             ex_ctrl_q;
    logic              hazard_c;
    logic              rs1_hit_c;
    logic              rs2_hit_c;
    logic [XLEN-1:0]   rs1_byp_c;
    logic [XLEN-1:0]   rs2_byp_c;

    assign ex_ctrl = ex_ctrl_q;

    // Load in EX whose destination feeds the instruction waiting in ID.
    always_comb begin
        hazard_c    = 1'b0;
        stall_if_id = 1'b0;
        if (ex_valid && ex_ctrl_q.mem_read && (ex_rd != REG_W'(0)) && id_valid &&
            ((ex_rd == id_rs1) || (ex_rd == id_rs2))) begin
            hazard_c = 1'b1;
        end
        stall_if_id = hazard_c && !flush && !reset;
    end

    // WB-to-ID bypass; x0 always reads the register file value.
    always_comb begin
        rs1_hit_c = wb_reg_write && (wb_rd != REG_W'(0)) && (wb_rd == id_rs1);
        rs2_hit_c = wb_reg_write && (wb_rd != REG_W'(0)) && (wb_rd == id_rs2);
        rs1_byp_c = rs1_hit_c ? wb_data : id_rs1_data;
        rs2_byp_c = rs2_hit_c ? wb_data : id_rs2_data;
    end

    // Pipeline register; flush and hazard both produce a fully cleared bubble.
    always_ff @(posedge clk) begin
        if (reset || flush || hazard_c) begin
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_imm      <= '0;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            ex_ctrl_q   <= '0;
            ex_aluop    <= '0;
        end else begin
            ex_valid    <= id_valid;
            ex_pc       <= id_pc;
            ex_imm      <= id_imm;
            ex_rs1_data <= rs1_byp_c;
            ex_rs2_data <= rs2_byp_c;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
            ex_ctrl_q   <= id_valid ? ctrl_t'(id_ctrl) : ctrl_t'('0);
            ex_aluop    <= id_aluop;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against a slot model
// fed by a shadow register file.
module tb_id_ex_stage;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned ALUOP_W = 4;
    localparam int MR = 5;  // mem_read position inside ctrl

    logic               clk = 1'b0;
    logic               reset, flush, id_valid;
    logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]         id_rs1, id_rs2, id_rd;
    logic [6:0]         id_ctrl;
    logic [ALUOP_W-1:0] id_aluop;
    logic               wb_reg_write;
    logic [4:0]         wb_rd;
    logic [XLEN-1:0]    wb_data;
    logic               stall_if_id, ex_valid;
    logic [XLEN-1:0]    ex_pc, ex_imm, ex_rs1_data, ex_rs2_data;
    logic [4:0]         ex_rs1, ex_rs2, ex_rd;
    logic [6:0]         ex_ctrl;
    logic [ALUOP_W-1:0] ex_aluop;

    id_ex_stage #(.XLEN(XLEN), .ALUOP_W(ALUOP_W)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rs1_data(id_rs1_data),
        .id_rs2_data(id_rs2_data), .id_imm(id_imm), .id_ctrl(id_ctrl), .id_aluop(id_aluop),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl), .ex_aluop(ex_aluop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               valid;
        logic [XLEN-1:0]    pc, imm, a, b;
        logic [4:0]         rs1, rs2, rd;
        logic [6:0]         ctrl;
        logic [ALUOP_W-1:0] aluop;
    } slot_t;

    slot_t           m;
    logic [XLEN-1:0] regs [32];
    int              checks = 0;
    int              errors = 0;
    logic            obs_stall;
    logic            exp_stall;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Newest architectural value of a source as seen at the end of this cycle.
    function automatic logic [XLEN-1:0] newest(input logic [4:0] rs, input logic [XLEN-1:0] rf);
        if (rs != 5'd0 && wb_reg_write && wb_rd == rs) return wb_data;
        return rf;
    endfunction

    task automatic drive_id(input logic v, input logic [XLEN-1:0] pc, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [4:0] rd,
                            input logic [XLEN-1:0] imm, input logic [6:0] ctrl,
                            input logic [ALUOP_W-1:0] op);
        @(negedge clk);
        id_valid = v; id_pc = pc; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_imm = imm; id_ctrl = ctrl; id_aluop = op;
        id_rs1_data = regs[rs1]; id_rs2_data = regs[rs2];
    endtask

    // Check the stall window, advance the model over the clock edge, check the EX slot.
    task automatic cycle();
        logic  load_use;
        slot_t nx;
        #1;
        load_use = m.valid && m.ctrl[MR] && m.rd != 5'd0 && id_valid &&
                   (m.rd == id_rs1 || m.rd == id_rs2);
        exp_stall = load_use && !flush && !reset;
        obs_stall = stall_if_id;
        check("stall_if_id", 64'(stall_if_id), 64'(exp_stall));
        nx = '{valid: 1'b0, pc: '0, imm: '0, a: '0, b: '0, rs1: '0, rs2: '0, rd: '0,
               ctrl: '0, aluop: '0};
        if (!reset && !flush && !load_use) begin
            nx.valid = id_valid; nx.pc = id_pc; nx.imm = id_imm;
            nx.a = newest(id_rs1, id_rs1_data); nx.b = newest(id_rs2, id_rs2_data);
            nx.rs1 = id_rs1; nx.rs2 = id_rs2; nx.rd = id_rd;
            nx.ctrl = id_valid ? id_ctrl : 7'd0; nx.aluop = id_aluop;
        end
        if (wb_reg_write && wb_rd != 5'd0) regs[wb_rd] = wb_data;
        @(posedge clk);
        m = nx;
        #1;
        check("ex_valid", 64'(ex_valid), 64'(m.valid));
        check("ex_ctrl", 64'(ex_ctrl), 64'(m.ctrl));
        check("ex_aluop", 64'(ex_aluop), 64'(m.aluop));
        check("ex_pc", ex_pc, m.pc);
        check("ex_imm", ex_imm, m.imm);
        check("ex_rs1_data", ex_rs1_data, m.a);
        check("ex_rs2_data", ex_rs2_data, m.b);
        check("ex_rs1", 64'(ex_rs1), 64'(m.rs1));
        check("ex_rs2", 64'(ex_rs2), 64'(m.rs2));
        check("ex_rd", 64'(ex_rd), 64'(m.rd));
    endtask

    localparam logic [6:0] C_LD  = 7'b1101100;
    localparam logic [6:0] C_ALU = 7'b1000000;
    localparam logic [6:0] C_IMM = 7'b1000100;

    initial begin
        logic [XLEN-1:0] all_ex;
        regs[0] = '0;
        for (int i = 1; i < 32; i++) regs[i] = {$urandom, $urandom};
        m = '{valid: 1'b0, pc: '0, imm: '0, a: '0, b: '0, rs1: '0, rs2: '0, rd: '0,
              ctrl: '0, aluop: '0};
        reset = 1'b1; flush = 1'b0; wb_reg_write = 1'b0; wb_rd = '0; wb_data = '0;

        // Reset with random ID traffic; stall forced low while in reset.
        for (int i = 0; i < 2; i++) begin
            drive_id(1'b1, {$urandom, $urandom}, 5'($urandom), 5'($urandom), 5'($urandom),
                     {$urandom, $urandom}, 7'($urandom), 4'($urandom));
            cycle();
        end
        all_ex = ex_pc | ex_imm | ex_rs1_data | ex_rs2_data |
                 64'({ex_rs1, ex_rs2, ex_rd, ex_ctrl, ex_aluop, ex_valid});
        check("reset_all_zero", all_ex, 64'd0);

        // Basic capture with a negative immediate.
        @(negedge clk); reset = 1'b0;
        drive_id(1'b1, 64'h100, 5'd3, 5'd0, 5'd1, -64'sd4, C_IMM, 4'd0);
        id_rs1_data = 64'h5;
        cycle();
        check("t2_pc", ex_pc, 64'h100);
        check("t2_rs1", ex_rs1_data, 64'h5);
        check("t2_imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFFC);
        check("t2_valid", 64'(ex_valid), 64'd1);

        // Load-use: one bubble, then the held instruction goes through.
        drive_id(1'b1, 64'h104, 5'd2, 5'd0, 5'd5, 64'd8, C_LD, 4'd0);
        cycle();
        drive_id(1'b1, 64'h108, 5'd1, 5'd5, 5'd6, 64'd0, C_ALU, 4'd2);
        cycle();
        check("t3_stall", 64'(obs_stall), 64'd1);
        check("t3_bubble", 64'(ex_valid), 64'd0);
        cycle();
        check("t3_nostall", 64'(obs_stall), 64'd0);
        check("t3_capture", 64'(ex_rs2), 64'd5);

        // WB bypass, then x0 never bypassed.
        drive_id(1'b1, 64'h10c, 5'd7, 5'd0, 5'd8, 64'd0, C_ALU, 4'd0);
        wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 64'hDEAD; id_rs1_data = '0;
        cycle();
        check("t4_bypass", ex_rs1_data, 64'hDEAD);
        drive_id(1'b1, 64'h110, 5'd0, 5'd0, 5'd8, 64'd0, C_ALU, 4'd0);
        wb_rd = 5'd0;
        cycle();
        check("t4_x0", ex_rs1_data, 64'd0);
        wb_reg_write = 1'b0;

        // Hazard and flush together: flush wins, no stall.
        drive_id(1'b1, 64'h114, 5'd1, 5'd0, 5'd5, 64'd0, C_LD, 4'd0);
        cycle();
        drive_id(1'b1, 64'h118, 5'd5, 5'd0, 5'd9, 64'd0, C_ALU, 4'd0);
        flush = 1'b1;
        cycle();
        check("t5_stall", 64'(obs_stall), 64'd0);
        check("t5_valid", 64'(ex_valid), 64'd0);
        flush = 1'b0;

        // Load to x0, and invalid ID, never stall.
        drive_id(1'b1, 64'h11c, 5'd1, 5'd0, 5'd0, 64'd0, C_LD, 4'd0);
        cycle();
        drive_id(1'b1, 64'h120, 5'd0, 5'd0, 5'd3, 64'd0, C_ALU, 4'd0);
        cycle();
        check("t6_x0", 64'(obs_stall), 64'd0);
        drive_id(1'b1, 64'h124, 5'd1, 5'd0, 5'd9, 64'd0, C_LD, 4'd0);
        cycle();
        drive_id(1'b0, 64'h128, 5'd9, 5'd9, 5'd3, 64'd0, C_ALU, 4'd0);
        cycle();
        check("t6_invalid", 64'(obs_stall), 64'd0);

        // Back-to-back dependent loads stall once each.
        drive_id(1'b1, 64'h12c, 5'd1, 5'd0, 5'd5, 64'd0, C_LD, 4'd0);
        cycle();
        drive_id(1'b1, 64'h130, 5'd5, 5'd0, 5'd6, 64'd0, C_LD, 4'd0);
        cycle();
        check("b2b_stall1", 64'(obs_stall), 64'd1);
        cycle();
        check("b2b_ld2", 64'(ex_valid), 64'd1);
        drive_id(1'b1, 64'h134, 5'd6, 5'd0, 5'd7, 64'd0, C_ALU, 4'd0);
        cycle();
        check("b2b_stall2", 64'(obs_stall), 64'd1);
        cycle();
        check("b2b_done", 64'(obs_stall), 64'd0);

        // Reset during a stall.
        drive_id(1'b1, 64'h138, 5'd1, 5'd0, 5'd4, 64'd0, C_LD, 4'd0);
        cycle();
        drive_id(1'b1, 64'h13c, 5'd4, 5'd0, 5'd2, 64'd0, C_ALU, 4'd0);
        reset = 1'b1;
        cycle();
        check("rst_stall", 64'(obs_stall), 64'd0);
        check("rst_valid", 64'(ex_valid), 64'd0);
        @(negedge clk); reset = 1'b0;

        // Random traffic; a stalled instruction is re-presented like a held IF/ID.
        for (int i = 0; i < 400; i++) begin
            if (exp_stall) begin
                @(negedge clk);
                id_rs1_data = regs[id_rs1]; id_rs2_data = regs[id_rs2];
            end else begin
                drive_id($urandom_range(0, 9) != 0, {$urandom, $urandom},
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), {$urandom, $urandom},
                         $urandom_range(0, 2) == 0 ? C_LD : 7'($urandom) & 7'b1011111,
                         4'($urandom));
            end
            flush = $urandom_range(0, 9) == 0;
            reset = $urandom_range(0, 49) == 0;
            wb_reg_write = $urandom_range(0, 1) == 1;
            wb_rd = 5'($urandom_range(0, 7));
            wb_data = {$urandom, $urandom};
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
